// File: rtl/pi_bus_pkg.sv
// Shared types and widths for the Raspberry Pi bus-transaction path.
// Also used by the Pi command decoder and the bus mux.
package pi_bus_pkg;

    localparam int PI_ADDR_WIDTH = 17;
    localparam int PI_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        ACTIVE  = 2'd2,
        DONE    = 2'd3
    } pi_bus_state_t;

endpackage

// File: rtl/edge_reg.sv
// One-cycle registered copy of a timing strobe, with rise/fall detection
// relative to that copy.
module edge_reg (
    input  logic clk16,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic r_q;

    // Delay the strobe by one clock.
    always_ff @(posedge clk16 or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= 1'b0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q    = r_q;
    assign o_rise = i_d & ~r_q;
    assign o_fall = ~i_d & r_q;

endmodule

// File: rtl/pi_bus_txn.sv
// Runs one Pi-initiated RAM/IO access inside the Pi slot of the 16-cycle bus frame.
// Bus enables are gated combinationally by pi_select so the bus is released on the falling edge.
module pi_bus_txn
    import pi_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = PI_ADDR_WIDTH,
    parameter int DATA_WIDTH = PI_DATA_WIDTH
) (
    input  logic                  clk16,
    input  logic                  reset_n,
    input  logic                  pi_select,
    input  logic                  pi_strobe,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wr_data,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rd_data,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_data_out,
    output logic                  bus_data_oe,
    output logic                  bus_addr_oe,
    output logic                  bus_we,
    input  logic [DATA_WIDTH-1:0] bus_data_in
);

    pi_bus_state_t         r_state;
    pi_bus_state_t         w_next_state;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_strobe_seen;

    logic w_sel_q;
    logic w_sel_rise;
    logic w_sel_fall;
    logic w_stb_q;
    logic w_stb_rise;
    logic w_stb_fall;
    logic w_accept;
    logic w_start;
    logic w_read_capture;
    logic w_unused;

    edge_reg u_sel_edge (
        .clk16   (clk16),
        .reset_n (reset_n),
        .i_d     (pi_select),
        .o_q     (w_sel_q),
        .o_rise  (w_sel_rise),
        .o_fall  (w_sel_fall)
    );

    edge_reg u_stb_edge (
        .clk16   (clk16),
        .reset_n (reset_n),
        .i_d     (pi_strobe),
        .o_q     (w_stb_q),
        .o_rise  (w_stb_rise),
        .o_fall  (w_stb_fall)
    );

    assign w_unused = &{1'b0, w_sel_q, w_sel_fall, w_stb_rise, w_stb_fall};

    assign w_accept = req_valid & (r_state == IDLE);
    // Only a fresh window start launches a transaction, never a mid-window request.
    assign w_start  = (r_state == PENDING) & w_sel_rise;
    // Second strobe cycle: the RAM/IO data is stable by then.
    assign w_read_capture = (r_state == ACTIVE) & pi_select & ~r_we & pi_strobe & w_stb_q;

    // FSM state register.
    always_ff @(posedge clk16 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = PENDING;
                end else begin
                    w_next_state = IDLE;
                end
            end
            PENDING: begin
                if (w_start) begin
                    w_next_state = ACTIVE;
                end else begin
                    w_next_state = PENDING;
                end
            end
            ACTIVE: begin
                // A window without any strobe is retried in the next frame.
                if (!pi_select) begin
                    if (r_strobe_seen) begin
                        w_next_state = DONE;
                    end else begin
                        w_next_state = PENDING;
                    end
                end else begin
                    w_next_state = ACTIVE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // FSM outputs: bus enables follow pi_select only while ACTIVE.
    always_comb begin
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        bus_addr_oe = 1'b0;
        bus_data_oe = 1'b0;
        bus_we      = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
            end
            ACTIVE: begin
                bus_addr_oe = pi_select;
                bus_data_oe = pi_select & r_we;
                bus_we      = pi_select & r_we & pi_strobe;
            end
            DONE: begin
                resp_valid = 1'b1;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    // Request latch, strobe tracking and read-data capture.
    always_ff @(posedge clk16 or negedge reset_n) begin
        if (!reset_n) begin
            r_we          <= 1'b0;
            r_addr        <= {ADDR_WIDTH{1'b0}};
            r_wr_data     <= {DATA_WIDTH{1'b0}};
            r_rd_data     <= {DATA_WIDTH{1'b0}};
            r_strobe_seen <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we      <= req_we;
                r_addr    <= req_addr;
                r_wr_data <= req_wr_data;
            end
            if (w_start) begin
                r_strobe_seen <= 1'b0;
            end else if ((r_state == ACTIVE) && pi_strobe) begin
                r_strobe_seen <= 1'b1;
            end
            if (w_read_capture) begin
                r_rd_data <= bus_data_in;
            end
        end
    end

    assign bus_addr     = r_addr;
    assign bus_data_out = r_wr_data;
    assign resp_rd_data = r_rd_data;

endmodule

// File: tb/tb_pi_bus_txn.sv
// Directed bench for pi_bus_txn: the bench generates the 16-cycle frame itself and
// scores responses against a queue of expected transactions.
module tb_pi_bus_txn;

    logic        clk16 = 1'b0;
    logic        reset_n;
    logic        pi_select;
    logic        pi_strobe;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [16:0] req_addr;
    logic [7:0]  req_wr_data;
    logic        resp_valid;
    logic [7:0]  resp_rd_data;
    logic [16:0] bus_addr;
    logic [7:0]  bus_data_out;
    logic        bus_data_oe;
    logic        bus_addr_oe;
    logic        bus_we;
    logic [7:0]  bus_data_in;

    typedef struct {
        logic        we;
        logic [16:0] addr;
        logic [7:0]  data;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_pass   = 0;
    int          n_total  = 0;
    int unsigned cyc      = 0;
    int          cnt      = 8;
    logic        suppress = 1'b0;
    logic [7:0]  rd_val   = 8'hFF;

    pi_bus_txn dut (
        .clk16        (clk16),
        .reset_n      (reset_n),
        .pi_select    (pi_select),
        .pi_strobe    (pi_strobe),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wr_data  (req_wr_data),
        .resp_valid   (resp_valid),
        .resp_rd_data (resp_rd_data),
        .bus_addr     (bus_addr),
        .bus_data_out (bus_data_out),
        .bus_data_oe  (bus_data_oe),
        .bus_addr_oe  (bus_addr_oe),
        .bus_we       (bus_we),
        .bus_data_in  (bus_data_in)
    );

    always #5 clk16 = ~clk16;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_frame();
        pi_select   = (cnt < 8);
        pi_strobe   = ((cnt == 2) || (cnt == 3)) && !suppress;
        bus_data_in = (cnt == 3) ? rd_val : 8'hFF;
    endtask

    task automatic monitor();
        exp_t e;
        chk("we_gate", 32'(bus_we & ~pi_select), 32'd0);
        if (bus_addr_oe) begin
            if (sb.size() == 0) begin
                chk("bus_owner", 32'(bus_addr_oe), 32'd0);
            end else begin
                chk("bus_addr", 32'(bus_addr), 32'(sb[0].addr));
                chk("data_oe", 32'(bus_data_oe), 32'(sb[0].we));
            end
        end
        if (bus_we && (sb.size() != 0)) begin
            chk("wr_data", 32'(bus_data_out), 32'(sb[0].data));
        end
        if (resp_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_resp", 32'(resp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_cycle", cyc, e.cyc);
                if (!e.we) begin
                    chk("rd_data", 32'(resp_rd_data), 32'(e.data));
                end
            end
        end
    endtask

    // Advance one clock: drive just after the rising edge, sample at the falling edge.
    task automatic step();
        @(posedge clk16);
        #1;
        cnt = (cnt + 1) % 16;
        cyc++;
        drive_frame();
        #4;
        monitor();
    endtask

    task automatic goto_cnt(input int c);
        do step(); while (cnt != c);
    endtask

    task automatic drain();
        for (int i = 0; (i < 64) && (sb.size() != 0); i++) begin
            step();
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    // Present a request in the current count; extra adds whole retry frames to the latency.
    task automatic issue(input logic we, input logic [16:0] addr, input logic [7:0] data,
                         input int extra, input logic hold);
        exp_t e;
        req_valid   = 1'b1;
        req_we      = we;
        req_addr    = addr;
        req_wr_data = data;
        chk("req_ready", 32'(req_ready), 32'd1);
        e.we   = we;
        e.addr = addr;
        e.data = we ? data : rd_val;
        e.cyc  = cyc + 32'(25 - cnt + extra);
        sb.push_back(e);
        step();
        if (!hold) begin
            req_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_addr    = 17'h00000;
        req_wr_data = 8'h00;
        drive_frame();
        step();
        step();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rd_data", 32'(resp_rd_data), 32'd0);
        chk("rst_bus_addr", 32'(bus_addr), 32'd0);
        chk("rst_bus_data", 32'(bus_data_out), 32'd0);
        chk("rst_addr_oe", 32'(bus_addr_oe), 32'd0);
        chk("rst_data_oe", 32'(bus_data_oe), 32'd0);
        chk("rst_we", 32'(bus_we), 32'd0);
        reset_n = 1'b1;

        // Write accepted at count 10 executes in the next frame.
        goto_cnt(10);
        issue(1'b1, 17'h08000, 8'hA5, 0, 1'b0);
        goto_cnt(0);
        chk("t1_c0_addr_oe", 32'(bus_addr_oe), 32'd0);
        step();
        chk("t1_c1_we", 32'(bus_we), 32'd0);
        chk("t1_c1_addr_oe", 32'(bus_addr_oe), 32'd1);
        step();
        chk("t1_c2_we", 32'(bus_we), 32'd1);
        chk("t1_c2_data_oe", 32'(bus_data_oe), 32'd1);
        chk("t1_c2_addr", 32'(bus_addr), 32'h08000);
        chk("t1_c2_data", 32'(bus_data_out), 32'hA5);
        step();
        chk("t1_c3_we", 32'(bus_we), 32'd1);
        step();
        chk("t1_c4_we", 32'(bus_we), 32'd0);
        chk("t1_c4_addr_oe", 32'(bus_addr_oe), 32'd1);
        goto_cnt(8);
        chk("t1_c8_addr_oe", 32'(bus_addr_oe), 32'd0);
        chk("t1_c8_data_oe", 32'(bus_data_oe), 32'd0);
        chk("t1_c8_we", 32'(bus_we), 32'd0);
        drain();

        // Best-case read accepted at count 15.
        goto_cnt(15);
        rd_val = 8'h3C;
        issue(1'b0, 17'h1F00F, 8'h00, 0, 1'b0);
        drain();
        chk("t2_rd_hold", 32'(resp_rd_data), 32'h3C);

        // Read accepted at count 0 waits out the current window.
        goto_cnt(0);
        rd_val = 8'h5A;
        issue(1'b0, 17'h1FFFF, 8'h00, 0, 1'b0);
        goto_cnt(2);
        chk("t3_c2_addr_oe", 32'(bus_addr_oe), 32'd0);
        chk("t3_c2_we", 32'(bus_we), 32'd0);
        goto_cnt(5);
        chk("t3_c5_addr_oe", 32'(bus_addr_oe), 32'd0);
        drain();

        // Strobe missing for one frame forces a retry.
        goto_cnt(10);
        issue(1'b1, 17'h00123, 8'h3C, 16, 1'b0);
        goto_cnt(0);
        suppress = 1'b1;
        goto_cnt(8);
        chk("t4_c8_addr_oe", 32'(bus_addr_oe), 32'd0);
        chk("t4_c8_data_oe", 32'(bus_data_oe), 32'd0);
        chk("t4_c8_we", 32'(bus_we), 32'd0);
        suppress = 1'b0;
        step();
        chk("t4_c9_resp", 32'(resp_valid), 32'd0);
        chk("t4_c9_ready", 32'(req_ready), 32'd0);
        goto_cnt(2);
        chk("t4_retry_we", 32'(bus_we), 32'd1);
        drain();

        // Back-to-back writes with req_valid held high.
        goto_cnt(10);
        for (int k = 0; k < 3; k++) begin
            if (k != 0) begin
                goto_cnt(10);
            end
            issue(1'b1, 17'h00A00 + 17'(k), 8'(17 * (k + 1)), 0, 1'b1);
        end
        req_valid = 1'b0;
        drain();

        // Reset in the middle of a write drops it with no response.
        goto_cnt(10);
        issue(1'b1, 17'h0ABCD, 8'h77, 0, 1'b0);
        goto_cnt(2);
        chk("t6_pre_we", 32'(bus_we), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_we", 32'(bus_we), 32'd0);
        chk("t6_rst_addr_oe", 32'(bus_addr_oe), 32'd0);
        chk("t6_rst_data_oe", 32'(bus_data_oe), 32'd0);
        chk("t6_rst_ready", 32'(req_ready), 32'd1);
        chk("t6_rst_rd_data", 32'(resp_rd_data), 32'd0);
        sb.delete();
        step();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
        end
        chk("t6_end_ready", 32'(req_ready), 32'd1);
        chk("t6_end_resp", 32'(resp_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pi_bus_txn.md
# pi_bus_txn

- Executes one Raspberry Pi–initiated RAM/IO transaction per request, inside the Pi time slot of the 16-cycle bus frame.
- Consumes `pi_select`/`pi_strobe` from the bus timing generator and drives address, data and write-enable onto the shared bus only while the Pi owns it.
- Returns read data and a completion pulse to the Pi-side command logic.

## Interface
Parameters:
- `ADDR_WIDTH`, 17, bus address width
- `DATA_WIDTH`, 8, bus data width

Ports:
- `clk16`  in  1  16 MHz system clock; all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `pi_select`  in  1  Pi owns bus (frame counts 0–7)
- `pi_strobe`  in  1  Pi data strobe (frame counts 2–3)
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept a request
- `req_we`  in  1  1 = write, 0 = read
- `req_addr`  in  ADDR_WIDTH  target address
- `req_wr_data`  in  DATA_WIDTH  write data
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rd_data`  out  DATA_WIDTH  read data; held until next accept
- `bus_addr`  out  ADDR_WIDTH  address to bus mux
- `bus_data_out`  out  DATA_WIDTH  write data to bus
- `bus_data_oe`  out  1  drive `bus_data_out`
- `bus_addr_oe`  out  1  drive `bus_addr`
- `bus_we`  out  1  write strobe to RAM/IO
- `bus_data_in`  in  DATA_WIDTH  data returned from bus

## Operation
States: `IDLE`, `PENDING`, `ACTIVE`, `DONE`.

- **IDLE**
  - `req_ready`=1.
  - On `req_valid & req_ready`: latch `we`, `addr`, `wr_data` and go to `PENDING`.
- **PENDING**
  - Wait for the rising edge of `pi_select`: `pi_select & !pi_select_q`, where `pi_select_q` is a 1-cycle registered copy.
  - On that edge, go to `ACTIVE` and clear `strobe_seen`.
  - A request latched while `pi_select` is already high waits for the next frame. A transaction never starts mid-window.
- **ACTIVE**
  - `bus_addr_oe` = `pi_select`; it is combinationally gated so the bus is released in the same cycle `pi_select` falls.
  - Write: `bus_data_oe` = `pi_select`; `bus_we` = `pi_select & pi_strobe`.
  - Read: on the cycle where `pi_strobe & pi_strobe_q` (2nd strobe cycle), capture `bus_data_in` into `resp_rd_data`.
  - `strobe_seen` sets on any `pi_strobe` cycle.
  - When `pi_select` is sampled low: if `strobe_seen`, go to `DONE`; otherwise return to `PENDING` and retry in the next frame. Latched request is unchanged; no response is issued.
- **DONE**
  - `resp_valid`=1 for exactly one cycle, `req_ready`=0, then go to `IDLE`.

Bus outputs outside `ACTIVE & pi_select`: `bus_*_oe`=0, `bus_we`=0. `bus_addr`/`bus_data_out` hold the latched values; they are don't-care when not enabled.

## Timing
- Reset: state=`IDLE`.
  - Outputs: `req_ready`=1, `resp_valid`=0, `resp_rd_data`=0, all `bus_*`=0.
  - `pi_select_q`, `pi_strobe_q`, `strobe_seen` = 0.
- Reset asserted mid-transaction: outputs return to reset values immediately (async). The in-flight request is dropped and no response is issued.
- Within a frame (count = frame position):
  - count 0: rising edge of `pi_select` detected.
  - count 1–7: `ACTIVE`, address driven.
  - count 2–3: `bus_we` asserted for writes.
  - end of count 3: read data captured.
  - count 8: outputs released, `pi_select` sampled low.
  - count 9: `resp_valid`.
  - count 10: `IDLE`, `req_ready`=1.
- Latency from accept to `resp_valid`:
  - Best case, accept at end of count 15: 10 cycles.
  - Accept at end of count 0: 25 cycles.
  - Maximum: 25 cycles (without retry).
- Throughput: at most one transaction per 16-cycle frame.
- `req_valid` held during `DONE` is accepted in `IDLE` (count 10), which makes the next frame.
- `pi_strobe` outside `ACTIVE` is ignored.

## Structure
- Package `pi_bus_pkg`:
  - `pi_bus_state_t` enum (`IDLE`/`PENDING`/`ACTIVE`/`DONE`).
  - `PI_ADDR_WIDTH`=17, `PI_DATA_WIDTH`=8, shared with the Pi command decoder and the bus mux.
- Sub-module `edge_reg`: registers `pi_select`/`pi_strobe` with async active-low reset and exposes `rise`/`fall`/`q`. The FSM, request latch and output gating stay in `pi_bus_txn`.

## Test plan
- Write at count 10, `addr`=0x08000, data 0xA5:
  - `bus_we` high exactly on counts 2–3 of the next frame with `bus_addr`=0x08000 and `bus_data_out`=0xA5.
  - `resp_valid` at count 9.
- Read at count 15, `bus_data_in`=0x3C on count 3 and 0xFF elsewhere: `resp_rd_data`=0x3C, with `resp_valid` 10 cycles after accept.
- Accept at count 0: no bus activity in the current window. The transaction executes in the following frame, with `resp_valid` 25 cycles after accept.
- Suppress `pi_strobe` for one frame:
  - Returns to `PENDING`, no `resp_valid`, all `bus_*_oe`=0 at count 8.
  - Completes normally in the next frame.
- Back-to-back: `req_valid` held high for 3 writes. Completions arrive exactly 16 cycles apart, with `bus_we` never asserted while `pi_select`=0.
- Assert `reset_n`=0 at count 2 of an active write: `bus_we`/`bus_*_oe` drop in the same cycle, and there is no `resp_valid` after release.
